load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_pkg.sv | 33 +++
 rtl/burst_address_counter.sv | 78 +++++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_pkg
//  Description : Shared definitions for the load/store unit: FSM state
//                encoding, default bus width and memory direction constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_pkg;

    // Default address/data width of the unit.
    localparam int BUS_WIDTH_DEFAULT = 8;

    // Only the low byte of the address selects a memory location.
    localparam int ADDR_SPACE_BITS = 8;

    // Values driven on memReadWriteControl.
    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    // Sequencer states. Writes take three cycles per beat so that address
    // and data settle before, and stay put after, the write strobe.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_SETUP   = 3'd1,
        WR_STROBE  = 3'd2,
        WR_HOLD    = 3'd3,
        RD_ADDR    = 3'd4,
        RD_CAPTURE = 3'd5,
        RD_RESP    = 3'd6
    } lsu_state_e;

endpackage : load_store_pkg
`default_nettype wire

// File: rtl/burst_address_counter.sv
`default_nettype none
// ============================================================================
//  Module      : burst_address_counter
//  Description : Holds the current beat address and the number of beats
//                still to go in a burst. The address increments modulo 256
//                (low byte only), so a burst started at 8'hFF continues
//                at 8'h00.
//  Ports       : clk          - clock, rising edge
//                rstN         - asynchronous active-low reset
//                load_i       - start a new burst (takes priority)
//                load_addr_i  - first beat address
//                load_len_i   - beats minus one
//                advance_i    - step to the next beat
//                addr_o       - current beat address
//                last_o       - high when no beats remain after this one
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_address_counter
    import load_store_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 load_i,
    input  logic [BUS_WIDTH-1:0] load_addr_i,
    input  logic [1:0]           load_len_i,
    input  logic                 advance_i,
    output logic [BUS_WIDTH-1:0] addr_o,
    output logic                 last_o
);

    logic [BUS_WIDTH-1:0]       addr_q;
    logic [BUS_WIDTH-1:0]       addr_d;
    logic [BUS_WIDTH-1:0]       addr_inc;
    logic [ADDR_SPACE_BITS-1:0] low_inc;
    logic [1:0]                 remaining_q;
    logic [1:0]                 remaining_d;

    // Only the memory-index byte counts; any upper bits ride along unchanged
    // so the wrap stays inside the 256-entry memory.
    assign low_inc = addr_q[ADDR_SPACE_BITS-1:0] + 8'd1;

    generate
        if (BUS_WIDTH > ADDR_SPACE_BITS) begin : g_wide
            assign addr_inc = {addr_q[BUS_WIDTH-1:ADDR_SPACE_BITS], low_inc};
        end else begin : g_byte
            assign addr_inc = low_inc;
        end
    endgenerate

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load_i) begin
            addr_d      = load_addr_i;
            remaining_d = load_len_i;
        end else if (advance_i) begin
            addr_d      = addr_inc;
            remaining_d = remaining_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr_q      <= '0;
            remaining_q <= 2'd0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (remaining_q == 2'd0);

endmodule : burst_address_counter
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Burst load/store sequencer in front of a simple
//                asynchronous-read data memory. Writes (fills) repeat one
//                data word over 1-4 consecutive addresses using a
//                setup/strobe/hold pattern; reads fetch 1-4 consecutive
//                words and hand each over with a valid/ready handshake.
//  Ports       : clk, rstN            - clock / async active-low reset
//                reqValid/reqReady    - request handshake
//                reqWrite             - 1 = fill, 0 = read
//                reqLength            - beats minus one
//                reqAddress, reqData  - start address, fill data
//                rspValid/rspReady    - read beat handshake
//                rspData, rspLast     - read beat data, final-beat flag
//                memAddress, memData  - memory address / write data
//                memReadWriteControl  - 1 = memory write strobe
//                memReadData          - combinational memory read data
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [1:0]           reqLength,
    input  logic [BUS_WIDTH-1:0] reqAddress,
    input  logic [BUS_WIDTH-1:0] reqData,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [BUS_WIDTH-1:0] rspData,
    output logic                 rspLast,
    output logic [BUS_WIDTH-1:0] memAddress,
    output logic [BUS_WIDTH-1:0] memData,
    output logic                 memReadWriteControl,
    input  logic [BUS_WIDTH-1:0] memReadData
);

    lsu_state_e           state_q;
    lsu_state_e           state_d;

    logic                 accept;
    logic                 advance;
    logic                 capture;

    logic                 rw_ctrl_q;
    logic                 rw_ctrl_d;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [BUS_WIDTH-1:0] wdata_d;
    logic [BUS_WIDTH-1:0] rsp_data_q;
    logic [BUS_WIDTH-1:0] rsp_data_d;
    logic                 rsp_last_q;
    logic                 rsp_last_d;

    logic [BUS_WIDTH-1:0] beat_addr;
    logic                 last_beat;

    // ------------------------------------------------------------------
    // Address / beat bookkeeping
    // ------------------------------------------------------------------
    burst_address_counter #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_burst_address_counter (
        .clk         (clk),
        .rstN        (rstN),
        .load_i      (accept),
        .load_addr_i (reqAddress),
        .load_len_i  (reqLength),
        .advance_i   (advance),
        .addr_o      (beat_addr),
        .last_o      (last_beat)
    );

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    accept  = 1'b1;
                    state_d = reqWrite ? WR_SETUP : RD_ADDR;
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
            WR_HOLD: begin
                // The address only moves on this edge, after the hold
                // cycle, so it is never disturbed right after a strobe.
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = WR_SETUP;
                end
            end
            RD_ADDR:   state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                capture = 1'b1;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rspReady) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = RD_ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe is decoded from the next state and registered, so the
        // memory sees a clean flop output that is high only in WR_STROBE.
        rw_ctrl_d  = (state_d == WR_STROBE) ? MEM_WRITE : MEM_READ;
        wdata_d    = accept  ? reqData     : wdata_q;
        rsp_data_d = capture ? memReadData : rsp_data_q;
        rsp_last_d = capture ? last_beat   : rsp_last_q;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            rw_ctrl_q  <= MEM_READ;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_ctrl_q  <= rw_ctrl_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign reqReady            = (state_q == IDLE);
    assign rspValid            = (state_q == RD_RESP);
    assign rspData             = rsp_data_q;
    assign rspLast             = rspValid & rsp_last_q;
    assign memAddress          = beat_addr;
    assign memData             = wdata_q;
    assign memReadWriteControl = rw_ctrl_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A byte array
//                behind the unit acts as the data memory; a second array
//                holds the expected memory image, updated from the request
//                semantics (fill writes one value over consecutive,
//                wrapping addresses).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic       clk        = 1'b0;
    logic       rstN       = 1'b0;
    logic       reqValid   = 1'b0;
    logic       reqReady;
    logic       reqWrite   = 1'b0;
    logic [1:0] reqLength  = 2'd0;
    logic [7:0] reqAddress = 8'h00;
    logic [7:0] reqData    = 8'h00;
    logic       rspValid;
    logic       rspReady   = 1'b0;
    logic [7:0] rspData;
    logic       rspLast;
    logic [7:0] memAddress;
    logic [7:0] memData;
    logic       memReadWriteControl;
    logic [7:0] memReadData;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         strobe_cnt = 0;
    int         n_checks   = 0;
    int         n_pass     = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BUS_WIDTH(8)) dut (
        .clk                 (clk),
        .rstN                (rstN),
        .reqValid            (reqValid),
        .reqReady            (reqReady),
        .reqWrite            (reqWrite),
        .reqLength           (reqLength),
        .reqAddress          (reqAddress),
        .reqData             (reqData),
        .rspValid            (rspValid),
        .rspReady            (rspReady),
        .rspData             (rspData),
        .rspLast             (rspLast),
        .memAddress          (memAddress),
        .memData             (memData),
        .memReadWriteControl (memReadWriteControl),
        .memReadData         (memReadData)
    );

    // Data memory: asynchronous read, write sampled mid-cycle of the strobe.
    assign memReadData = mem[memAddress];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(negedge clk);
            if (memReadWriteControl === 1'b1) begin
                mem[memAddress] = memData;
                strobe_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    task automatic issue(input logic wr, input logic [1:0] len,
                         input logic [7:0] addr, input logic [7:0] data);
        int guard;
        guard = 0;
        @(negedge clk);
        while (reqReady !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (reqReady !== 1'b1) $display("FAIL issue_ready: reqReady=%b required 1", reqReady);
        else n_pass++;
        reqValid   = 1'b1;
        reqWrite   = wr;
        reqLength  = len;
        reqAddress = addr;
        reqData    = data;
        @(posedge clk);
        #1;
        reqValid   = 1'b0;
        reqWrite   = 1'($urandom);
        reqLength  = 2'($urandom);
        reqAddress = 8'($urandom);
        reqData    = 8'($urandom);
    endtask

    task automatic do_write(input logic [1:0] len, input logic [7:0] addr,
                            input logic [7:0] data, input string tag);
        int         beats;
        int         cyc;
        int         strobes;
        logic       prev_rwc;
        logic [7:0] prev_addr;
        beats     = int'(len) + 1;
        cyc       = 0;
        strobes   = 0;
        prev_rwc  = 1'b0;
        prev_addr = addr;
        issue(1'b1, len, addr, data);
        do begin
            @(negedge clk);
            cyc++;
            if (prev_rwc) begin
                n_checks++;
                if (memAddress !== prev_addr)
                    $display("FAIL %s post_strobe_addr: got %h required %h", tag, memAddress, prev_addr);
                else n_pass++;
            end
            if (memReadWriteControl === 1'b1) begin
                n_checks++;
                if (memAddress !== 8'(int'(addr) + strobes) || memData !== data)
                    $display("FAIL %s strobe_addr_data: got %h/%h required %h/%h", tag,
                             memAddress, memData, 8'(int'(addr) + strobes), data);
                else n_pass++;
                strobes++;
            end
            prev_rwc  = memReadWriteControl;
            prev_addr = memAddress;
        end while (reqReady !== 1'b1 && cyc < 40);

        n_checks++;
        if (cyc != 3 * beats + 1)
            $display("FAIL %s ready_latency: got %0d required %0d", tag, cyc, 3 * beats + 1);
        else n_pass++;
        n_checks++;
        if (strobes != beats)
            $display("FAIL %s strobe_count: got %0d required %0d", tag, strobes, beats);
        else n_pass++;

        for (int i = 0; i < beats; i++) ref_mem[8'(int'(addr) + i)] = data;
        for (int i = 0; i < beats; i++) begin
            n_checks++;
            if (mem[8'(int'(addr) + i)] !== ref_mem[8'(int'(addr) + i)])
                $display("FAIL %s mem_content[%h]: got %h required %h", tag, 8'(int'(addr) + i),
                         mem[8'(int'(addr) + i)], ref_mem[8'(int'(addr) + i)]);
            else n_pass++;
        end
    endtask

    task automatic do_read(input logic [1:0] len, input logic [7:0] addr,
                           input int stall, input string tag);
        int         n_beats;
        int         beat;
        int         waited;
        int         guard;
        logic [7:0] exp_d;
        logic       exp_l;
        logic [7:0] hold_d;
        logic [7:0] hold_a;
        logic       hold_l;
        n_beats = int'(len) + 1;
        beat    = 0;
        waited  = 0;
        guard   = 0;
        hold_d  = 8'h00;
        hold_a  = 8'h00;
        hold_l  = 1'b0;
        rspReady = (stall == 0);
        issue(1'b0, len, addr, 8'h00);
        while (beat < n_beats && guard < 200) begin
            @(negedge clk);
            guard++;
            if (rspValid === 1'b1) begin
                if (waited == 0) begin
                    if (beat == 0) begin
                        n_checks++;
                        if (guard != 3)
                            $display("FAIL %s first_rsp_latency: got %0d required 3", tag, guard);
                        else n_pass++;
                    end
                    exp_d = ref_mem[8'(int'(addr) + beat)];
                    exp_l = (beat == n_beats - 1);
                    n_checks++;
                    if (rspData !== exp_d)
                        $display("FAIL %s rsp_data beat %0d: got %h required %h", tag, beat, rspData, exp_d);
                    else n_pass++;
                    n_checks++;
                    if (rspLast !== exp_l)
                        $display("FAIL %s rsp_last beat %0d: got %b required %b", tag, beat, rspLast, exp_l);
                    else n_pass++;
                    hold_d = rspData;
                    hold_l = rspLast;
                    hold_a = memAddress;
                end else begin
                    n_checks++;
                    if (rspData !== hold_d || rspLast !== hold_l || memAddress !== hold_a)
                        $display("FAIL %s stall_stable: got %h/%b/%h required %h/%b/%h", tag,
                                 rspData, rspLast, memAddress, hold_d, hold_l, hold_a);
                    else n_pass++;
                end
                if (waited >= stall) begin
                    rspReady = 1'b1;
                    beat++;
                    waited = 0;
                end else begin
                    rspReady = 1'b0;
                    waited++;
                end
            end else begin
                rspReady = (stall == 0);
            end
        end
        n_checks++;
        if (beat != n_beats)
            $display("FAIL %s beat_count: got %0d required %0d", tag, beat, n_beats);
        else n_pass++;
        @(negedge clk);
        rspReady = 1'b0;
        n_checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0)
            $display("FAIL %s end_idle: got ready=%b valid=%b required 1/0", tag, reqReady, rspValid);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #12;
        n_checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0 || rspLast !== 1'b0 || rspData !== 8'h00)
            $display("FAIL reset_rsp: got ready=%b valid=%b last=%b data=%h required 1/0/0/00",
                     reqReady, rspValid, rspLast, rspData);
        else n_pass++;
        n_checks++;
        if (memAddress !== 8'h00 || memData !== 8'h00 || memReadWriteControl !== 1'b0)
            $display("FAIL reset_mem: got addr=%h data=%h rw=%b required 00/00/0",
                     memAddress, memData, memReadWriteControl);
        else n_pass++;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(2'd0, 8'h10, 8'h3C, "wr_single");
        do_read(2'd0, 8'h10, 0, "rd_single");
    endtask

    task automatic test_read_wrap();
        do_write(2'd0, 8'hFE, 8'h01, "pre_fe");
        do_write(2'd0, 8'hFF, 8'h02, "pre_ff");
        do_write(2'd0, 8'h00, 8'h03, "pre_00");
        do_write(2'd0, 8'h01, 8'h04, "pre_01");
        do_read(2'd3, 8'hFE, 0, "rd_wrap");
    endtask

    task automatic test_fill_wrap();
        do_write(2'd2, 8'hFF, 8'hAA, "fill_wrap");
    endtask

    task automatic test_backpressure();
        do_read(2'd1, 8'h40, 5, "rd_backpressure");
    endtask

    task automatic test_reset_during_write();
        int start_cnt;
        start_cnt = strobe_cnt;
        issue(1'b1, 2'd0, 8'h42, 8'h99);
        @(posedge clk);
        #2;
        n_checks++;
        if (memReadWriteControl !== 1'b1)
            $display("FAIL rst_wr strobe_high: got %b required 1", memReadWriteControl);
        else n_pass++;
        rstN = 1'b0;
        #1;
        n_checks++;
        if (memReadWriteControl !== 1'b0 || reqReady !== 1'b1 || rspValid !== 1'b0)
            $display("FAIL rst_wr async_clear: got rw=%b ready=%b valid=%b required 0/1/0",
                     memReadWriteControl, reqReady, rspValid);
        else n_pass++;
        n_checks++;
        if (memAddress !== 8'h00 || memData !== 8'h00)
            $display("FAIL rst_wr mem_bus: got %h/%h required 00/00", memAddress, memData);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        n_checks++;
        if (strobe_cnt != start_cnt || mem[8'h42] !== ref_mem[8'h42])
            $display("FAIL rst_wr no_write: got strobes=%0d mem=%h required %0d/%h",
                     strobe_cnt - start_cnt, mem[8'h42], 0, ref_mem[8'h42]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (reqReady !== 1'b1 || memReadWriteControl !== 1'b0)
            $display("FAIL rst_wr idle_after: got ready=%b rw=%b required 1/0", reqReady, memReadWriteControl);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic [1:0] l;
            logic [7:0] a;
            logic [7:0] d;
            l = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(l, a, d, "rand_wr");
            else                           do_read(l, a, int'($urandom_range(0, 3)), "rand_rd");
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_write_read();
        test_read_wrap();
        test_fill_wrap();
        test_backpressure();
        test_reset_during_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
